// File: rtl/dq_align_pkg.sv
// Shared types and widths for the DDR3 read-data aligner.
// Optional per-lane automatic slip is enabled by defining DQ_ALIGN_AUTOSLIP_EN.
package dq_align_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;
    localparam int SLIP_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    // Window over {din_now, din_prev}: slip s delays the stream by s bits.
    function automatic logic [NIB_W-1:0] slip_window(input logic [BYTE_W-1:0] hist,
                                                     input logic [SLIP_W-1:0] s);
        logic [NIB_W-1:0] w;
        case (s)
            2'd0:    w = hist[7:4];
            2'd1:    w = hist[6:3];
            2'd2:    w = hist[5:2];
            default: w = hist[4:1];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dq_lane_slip.sv
// One DQ lane: bit-slip window, nibble pairing into a byte, and training compare.
// With DQ_ALIGN_AUTOSLIP_EN defined the lane owns a slip register that steps on mismatch.
module dq_lane_slip
    import dq_align_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NIB_W-1:0]  din,
    input  logic [SLIP_W-1:0] slip,
    input  logic              capture_low,
    input  logic              capture_high,
    input  logic              cmp_en,
    input  logic              train_en,
    input  logic [BYTE_W-1:0] train_pattern,
    output logic [BYTE_W-1:0] byte_out,
    output logic              train_match,
    output logic [SLIP_W-1:0] slip_cur
);

    logic [NIB_W-1:0] din_prev;
    logic [NIB_W-1:0] aligned_r;
    logic [NIB_W-1:0] low_r;

    // NOTE: sequential state uses <= so every register samples pre-edge values,
    // which is what makes the 1-cycle window latency independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_prev  <= '0;
            aligned_r <= '0;
            low_r     <= '0;
            byte_out  <= '0;
        end else begin
            din_prev  <= din;
            aligned_r <= slip_window({din, din_prev}, slip_cur);
            if (capture_low) begin
                low_r <= aligned_r;
            end
            if (capture_high) begin
                byte_out <= {aligned_r, low_r};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            train_match <= 1'b0;
        end else if (!train_en) begin
            train_match <= 1'b0;
        end else if (cmp_en) begin
            train_match <= (byte_out == train_pattern);
        end
    end

`ifdef DQ_ALIGN_AUTOSLIP_EN
    logic              mismatch;
    logic [SLIP_W-1:0] slip_r;

    assign mismatch = train_en && cmp_en && (byte_out != train_pattern);

    // Follows the controller while not training; hunts for the eye while training.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slip_r <= '0;
        end else if (!train_en) begin
            slip_r <= slip;
        end else if (mismatch) begin
            slip_r <= slip_r + 1'b1;
        end
    end

    assign slip_cur = slip_r;
`else
    assign slip_cur = slip;
`endif

endmodule

// File: rtl/dq_read_aligner.sv
// Read-data capture for DDR3 byte lanes: latency line, burst FSM and per-lane alignment.
// Define DQ_ALIGN_AUTOSLIP_EN to let training adjust each lane's slip automatically.
module dq_read_aligner
    import dq_align_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int MAX_LAT = 16,
    parameter int LAT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*LANES-1:0]   din,
    input  logic                 rd_start,
    input  logic [LAT_W-1:0]     rd_lat,
    input  logic [2*LANES-1:0]   slip,
    input  logic                 train_en,
    input  logic [7:0]           train_pattern,
    output logic [8*LANES-1:0]   dout,
    output logic                 dout_valid,
    output logic                 rd_overrun,
    output logic [LANES-1:0]     train_match,
    output logic [2*LANES-1:0]   slip_cur,
    output logic                 busy
);

    logic [MAX_LAT-1:0] lat_sr;
    logic               tap;
    state_t             state;

    // NOTE: the delay line is reset along with the FSM so a burst aborted by
    // rst_n cannot resurface after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_sr <= '0;
        end else begin
            lat_sr <= {lat_sr[MAX_LAT-2:0], rd_start};
        end
    end

    // NOTE: tap gets a default before the selection so no latch is inferred.
    always_comb begin
        tap = 1'b0;
        if (rd_lat == '0) begin
            tap = rd_start;
        end else begin
            for (int k = 1; k < MAX_LAT; k++) begin
                if (int'(rd_lat) == k) begin
                    tap = lat_sr[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
            rd_overrun <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            rd_overrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tap) begin
                        state <= FIRST;
                    end
                end
                FIRST: begin
                    // A second tap here would overlap the burst being paired.
                    rd_overrun <= tap;
                    state      <= SECOND;
                end
                SECOND: begin
                    dout_valid <= 1'b1;
                    state      <= tap ? FIRST : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (|lat_sr) || (state != IDLE);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dq_lane_slip u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .din           (din[NIB_W*i +: NIB_W]),
            .slip          (slip[SLIP_W*i +: SLIP_W]),
            .capture_low   (state == FIRST),
            .capture_high  (state == SECOND),
            .cmp_en        (dout_valid),
            .train_en      (train_en),
            .train_pattern (train_pattern),
            .byte_out      (dout[BYTE_W*i +: BYTE_W]),
            .train_match   (train_match[i]),
            .slip_cur      (slip_cur[SLIP_W*i +: SLIP_W])
        );
    end

endmodule
